// File: rtl/pc_fetch.sv
// pc_fetch -- program-counter register and instruction-fetch sequencer for
// the multi-cycle MIPS core.
//
// Holds the PC, fetches the word at PC over a valid/ready request plus a
// valid-only response, buffers it for decode, and on the decode handoff
// loads the next PC supplied by the next-PC calculator.
//
// Ports:
//   clk, rst                        rising-edge clock, async active-high reset
//   pc            out [31:0]        current PC (to next-PC calculator)
//   npc_in        in  [31:0]        next PC, sampled only on handoff
//   halt          in                suppresses starting a new request
//   imem_req_valid/ready, imem_addr instruction memory request channel
//   imem_rsp_valid, imem_rsp_data   instruction memory response
//   if_valid/ready, if_instr, if_pc buffered instruction to decode
//   fetch_cnt     out [CNT_W-1:0]   completed handoffs, wraps silently
//   busy          out               fetch in flight or instruction held
//   misalign      out               only with PC_ALIGN_CHECK_EN
//
// Optional build macro: PC_ALIGN_CHECK_EN -- a handoff with npc_in[1:0] != 0
// still loads pc but raises misalign and parks the sequencer in S_TRAP
// until reset.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      pc,
    input  logic [31:0]      npc_in,
    input  logic             halt,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             busy
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             misalign
`endif
);

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t state, state_nxt;

    logic req_fire;
    logic rsp_take;
    logic handoff;

    assign req_fire  = imem_req_valid & imem_req_ready;
    assign rsp_take  = (state == S_WAIT) & imem_rsp_valid;
    assign handoff   = if_valid & if_ready;
    assign imem_addr = pc;

`ifdef PC_ALIGN_CHECK_EN
    logic npc_bad;
    assign npc_bad = |npc_in[1:0];
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (req_fire) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (handoff) begin
`ifdef PC_ALIGN_CHECK_EN
                    state_nxt = npc_bad ? S_TRAP : S_REQ;
`else
                    state_nxt = S_REQ;
`endif
                end
            end
            default: state_nxt = state;
        endcase
    end

    // Output logic; state already sits in S_REQ during reset, so the
    // request is additionally masked by rst itself.
    always_comb begin
        imem_req_valid = 1'b0;
        if_valid       = 1'b0;
        busy           = 1'b0;
        case (state)
            S_REQ:  imem_req_valid = !halt && !rst;
            S_WAIT: busy = 1'b1;
            S_HOLD: begin
                if_valid = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    // PC, instruction buffer and handoff counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            if_instr  <= '0;
            if_pc     <= '0;
            fetch_cnt <= '0;
        end else begin
            if (rsp_take) begin
                if_instr <= imem_rsp_data;
                if_pc    <= pc;
            end
            if (handoff) begin
                pc        <= npc_in;
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
        end else if (handoff && npc_bad) begin
            misalign <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch -- self-checking bench for pc_fetch.
// The bench plays instruction memory and decode. A transaction-level model
// (expected PC, pending memory access, held instruction, handoff count)
// predicts every visible output each cycle.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int unsigned CW     = 4;   // small counter so wrap is reached

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   pc;
    logic [31:0]   npc_in = '0;
    logic          halt = 1'b0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [31:0]   imem_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [31:0]   imem_rsp_data = '0;
    logic          if_valid;
    logic          if_ready = 1'b0;
    logic [31:0]   if_instr;
    logic [31:0]   if_pc;
    logic [CW-1:0] fetch_cnt;
    logic          busy;
`ifdef PC_ALIGN_CHECK_EN
    logic          misalign;
`endif

    pc_fetch #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .npc_in         (npc_in),
        .halt           (halt),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_cnt      (fetch_cnt),
        .busy           (busy)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign       (misalign)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357_9BDF;
    endfunction

    // Model state
    logic [31:0] m_pc;
    int unsigned m_cnt;
    bit          m_pending, m_have, m_trap;
    int unsigned m_wait;
    int unsigned cyc, dut_acc, dut_ho;
    logic [31:0] ho_pc[$];
    int unsigned ho_cyc[$];

    // Stimulus knobs
    bit          c_rdy, c_drdy, c_halt, c_spur;
    int unsigned c_lat;
    int unsigned c_npc_mode;          // 0: pc+4 with one branch, 1: random
    logic [31:0] br_at, br_to;

    task automatic model_reset();
        m_pc = RST_PC; m_cnt = 0;
        m_pending = 1'b0; m_have = 1'b0; m_trap = 1'b0; m_wait = 0;
    endtask

    // Reset asserted mid-cycle; outputs must respond without a clock edge.
    task automatic do_reset();
        #3;
        halt = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; if_ready = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("rst_pc", pc, RST_PC);
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
        check_eq("rst_if_instr", if_instr, 32'd0);
        check_eq("rst_if_pc", if_pc, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
`ifdef PC_ALIGN_CHECK_EN
        check_eq("rst_misalign", 32'(misalign), 32'd0);
`endif
        model_reset();
        @(posedge clk); #1;
        check_eq("rst_hold_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_hold_pc", pc, RST_PC);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // advance across the edge, then update the model from what occurred.
    task automatic cycle();
        logic [31:0] npc;
        bit          rsp, fire, ho, req_exp;
        if (c_npc_mode == 0) begin
            npc = (m_pc == br_at) ? br_to : m_pc + 32'd4;
        end else begin
            npc = $urandom;
`ifdef PC_ALIGN_CHECK_EN
            npc[1:0] = 2'b00;
`endif
            if ($urandom_range(0, 9) == 0) npc = 32'hFFFF_FFFC;
            if (m_pc == 32'hFFFF_FFFC) npc = m_pc + 32'd4;
        end
        rsp = m_pending && (m_wait == 1);
        imem_req_ready = c_rdy;
        if_ready       = c_drdy;
        halt           = c_halt;
        npc_in         = npc;
        imem_rsp_valid = rsp || (c_spur && !m_pending && !m_have && ($urandom_range(0, 2) == 0));
        imem_rsp_data  = rsp ? mem_word(m_pc) : $urandom;
        #1;
        req_exp = !m_trap && !m_pending && !m_have && !c_halt;
        fire    = req_exp && c_rdy;
        ho      = m_have && c_drdy;
        check_eq("pc", pc, m_pc);
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("req_valid", 32'(imem_req_valid), 32'(req_exp));
        check_eq("if_valid", 32'(if_valid), 32'(m_have));
        check_eq("busy", 32'(busy), 32'(m_pending || m_have));
        check_eq("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt[CW-1:0]));
        if (m_have) begin
            check_eq("if_pc", if_pc, m_pc);
            check_eq("if_instr", if_instr, mem_word(m_pc));
        end
`ifdef PC_ALIGN_CHECK_EN
        check_eq("misalign", 32'(misalign), 32'(m_trap));
`endif
        if (imem_req_valid && c_rdy) dut_acc++;
        if (if_valid && c_drdy) dut_ho++;
        @(posedge clk); #1;
        cyc++;
        if (fire) begin
            m_pending = 1'b1;
            m_wait    = c_lat;
        end else if (m_pending) begin
            if (rsp) begin
                m_pending = 1'b0;
                m_have    = 1'b1;
            end else begin
                m_wait--;
            end
        end
        if (ho) begin
            ho_pc.push_back(m_pc);
            ho_cyc.push_back(cyc);
            m_pc   = npc;
            m_cnt++;
            m_have = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (npc[1:0] != 2'b00) m_trap = 1'b1;
`endif
        end
    endtask

    task automatic seq_cfg();
        c_rdy = 1'b1; c_drdy = 1'b1; c_halt = 1'b0; c_spur = 1'b0;
        c_lat = 1; c_npc_mode = 0; br_at = 32'h1; br_to = 32'h0;
        ho_pc.delete(); ho_cyc.delete();
    endtask

    int unsigned a0, h0;

    initial begin
        cyc = 0; dut_acc = 0; dut_ho = 0;
        model_reset();
        seq_cfg();

        // Sequential zero-wait fetch: 3000, 3004, 3008 every 3 cycles
        do_reset();
        seq_cfg();
        repeat (9) cycle();
        check_eq("seq_handoffs", 32'(ho_pc.size()), 32'd3);
        if (ho_pc.size() >= 3) begin
            check_eq("seq_pc0", ho_pc[0], 32'h0000_3000);
            check_eq("seq_pc1", ho_pc[1], 32'h0000_3004);
            check_eq("seq_pc2", ho_pc[2], 32'h0000_3008);
            check_eq("seq_gap1", ho_cyc[1] - ho_cyc[0], 32'd3);
            check_eq("seq_gap2", ho_cyc[2] - ho_cyc[1], 32'd3);
        end
        check_eq("seq_cnt", 32'(fetch_cnt), 32'd3);

        // Branch redirect at 3004 -> 3040
        do_reset();
        seq_cfg();
        br_at = 32'h0000_3004; br_to = 32'h0000_3040;
        repeat (9) cycle();
        check_eq("br_handoffs", 32'(ho_pc.size()), 32'd3);
        if (ho_pc.size() >= 3) check_eq("br_pc2", ho_pc[2], 32'h0000_3040);
        check_eq("br_pc", pc, 32'h0000_3044);

        // Backpressure on every channel
        do_reset();
        seq_cfg();
        a0 = dut_acc; h0 = dut_ho;
        c_rdy = 1'b0; c_drdy = 1'b0; c_lat = 5;
        repeat (4) cycle();
        check_eq("bp_no_accept", dut_acc - a0, 32'd0);
        c_rdy = 1'b1; cycle(); c_rdy = 1'b0;
        repeat (5) cycle();
        check_eq("bp_holding", 32'(if_valid), 32'd1);
        repeat (3) cycle();
        c_drdy = 1'b1; cycle(); c_drdy = 1'b0;
        repeat (3) cycle();
        check_eq("bp_one_accept", dut_acc - a0, 32'd1);
        check_eq("bp_one_handoff", dut_ho - h0, 32'd1);
        check_eq("bp_cnt", 32'(fetch_cnt), 32'd1);

        // Halt before acceptance withdraws; halt during wait lets fetch finish
        do_reset();
        seq_cfg();
        c_rdy = 1'b0;
        repeat (2) cycle();
        c_halt = 1'b1; cycle();
        check_eq("halt_pc", pc, RST_PC);
        c_halt = 1'b0; c_rdy = 1'b1; cycle();
        c_halt = 1'b1; c_lat = 2;
        a0 = dut_acc; h0 = dut_ho;
        repeat (6) cycle();
        check_eq("halt_handoff", dut_ho - h0, 32'd1);
        check_eq("halt_no_req", dut_acc - a0, 32'd0);
        c_halt = 1'b0; cycle();
        check_eq("halt_resume", dut_acc - a0, 32'd1);

        // Misaligned next PC
        do_reset();
        seq_cfg();
        br_at = 32'h0000_3004; br_to = 32'h0000_3002;
        repeat (6) cycle();
        check_eq("mis_pc", pc, 32'h0000_3002);
        a0 = dut_acc;
        repeat (5) cycle();
`ifdef PC_ALIGN_CHECK_EN
        check_eq("mis_flag", 32'(misalign), 32'd1);
        check_eq("mis_no_req", dut_acc - a0, 32'd0);
`else
        check_eq("mis_fetched", dut_acc - a0, 32'd2);
`endif

        // Randomized traffic with occasional mid-flight resets
        do_reset();
        seq_cfg();
        c_npc_mode = 1; c_spur = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            c_rdy  = ($urandom_range(0, 9) < 6);
            c_drdy = ($urandom_range(0, 9) < 6);
            c_halt = ($urandom_range(0, 9) < 2);
            c_lat  = $urandom_range(1, 6);
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
